adc_receiver: RTL and testbench

ADC_RECEIVER -- requirements
Module: adc_receiver

---
 rtl/audio_pkg.sv | 13 +
 rtl/adc_receiver_if.sv | 13 +
 rtl/serial_input_sync.sv | 44 ++++
 rtl/adc_receiver.sv | 185 ++++++++++++++++++
 tb/tb_adc_receiver.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions: default word width and receiver state encoding.
package audio_pkg;

    // Bits per channel word, shared with the matching transmitter.
    localparam int AUDIO_WIDTH = 24;

    // Receiver FSM state encoding.
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t LEFT  = 2'd1;
    localparam state_t RIGHT = 2'd2;

endpackage

// File: rtl/adc_receiver_if.sv
// Serial audio bus: bit clock, word select and data line.
interface adc_receiver_if;

    logic sclk;
    logic lrclk;
    logic sd;

    // The serial source drives the bus.
    modport master (output sclk, output lrclk, output sd);
    // The receiver only observes the bus.
    modport slave  (input sclk, input lrclk, input sd);

endinterface

// File: rtl/serial_input_sync.sv
// Brings the asynchronous serial bus into the clk domain and flags
// synchronized sclk rising edges as sample events.
module serial_input_sync (
    input  logic                 clk,
    input  logic                 rst_n,
    adc_receiver_if.slave        bus,
    output logic                 sample_en,
    output logic                 lr_s,
    output logic                 sd_s
);

    // Index 0 is the first synchronizer stage; sclk has an extra stage for edge detect.
    logic [2:0] sclk_q, sclk_d;
    logic [1:0] lr_q,   lr_d;
    logic [1:0] sd_q,   sd_d;

    // Shift each raw line one stage deeper per clk.
    // NOTE: every variable written here gets its value on every path, so no latch is inferred.
    always_comb begin
        sclk_d = {sclk_q[1:0], bus.sclk};
        lr_d   = {lr_q[0],     bus.lrclk};
        sd_d   = {sd_q[0],     bus.sd};
    end

    // Synchronizer flops, cleared on reset.
    // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            lr_q   <= '0;
            sd_q   <= '0;
        end else begin
            sclk_q <= sclk_d;
            lr_q   <= lr_d;
            sd_q   <= sd_d;
        end
    end

    // All three lines share the same depth, so lr_s/sd_s line up with the edge.
    assign sample_en = sclk_q[1] & ~sclk_q[2];
    assign lr_s      = lr_q[1];
    assign sd_s      = sd_q[1];

endmodule

// File: rtl/adc_receiver.sv
// Left-justified stereo serial receiver: assembles left/right words and
// presents each completed frame with a one-clk valid pulse.
module adc_receiver
    import audio_pkg::*;
#(
    parameter int WIDTH = AUDIO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sclk,
    input  logic             lrclk,
    input  logic             sd,
    output logic [WIDTH-1:0] left_data,
    output logic [WIDTH-1:0] right_data,
    output logic             valid,
    output logic             frame_err
);

    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  FULL = CW'(WIDTH);

    adc_receiver_if serial_bus ();
    assign serial_bus.sclk  = sclk;
    assign serial_bus.lrclk = lrclk;
    assign serial_bus.sd    = sd;

    logic sample_en;
    logic lr_s;
    logic sd_s;

    serial_input_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (serial_bus),
        .sample_en (sample_en),
        .lr_s      (lr_s),
        .sd_s      (sd_s)
    );

    state_t           state_q,      state_d;
    logic             lr_prev_q,    lr_prev_d;
    logic [CW-1:0]    cnt_q,        cnt_d;
    logic [WIDTH-1:0] left_sr_q,    left_sr_d;
    logic [WIDTH-1:0] right_sr_q,   right_sr_d;
    logic             left_short_q, left_short_d;
    logic [WIDTH-1:0] left_data_q,  left_data_d;
    logic [WIDTH-1:0] right_data_q, right_data_d;
    logic             valid_q,      valid_d;
    logic             frame_err_q,  frame_err_d;

    logic             boundary;
    logic             not_full;
    logic [CW-1:0]    shamt;
    logic             start_left;
    logic             start_right;
    logic             shift_en;
    logic             frame_done;

    // A word-select change seen at a sample event marks a new channel's MSB.
    assign boundary = sample_en && (lr_s != lr_prev_q);
    assign not_full = cnt_q < FULL;
    // Left-justifies a short word: received bits move to the MSBs.
    assign shamt    = FULL - cnt_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: channel boundaries move between LEFT and RIGHT.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else if (boundary) begin
            case (state_q)
                IDLE:    if (lr_s)  state_d = LEFT;
                LEFT:    if (!lr_s) state_d = RIGHT;
                RIGHT:   if (lr_s)  state_d = LEFT;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode: datapath controls derived from state and the current event.
    always_comb begin
        start_left  = 1'b0;
        start_right = 1'b0;
        frame_done  = 1'b0;
        if (enable && boundary) begin
            case (state_q)
                IDLE:    start_left  = lr_s;
                LEFT:    start_right = !lr_s;
                RIGHT: begin
                    start_left = lr_s;
                    frame_done = lr_s;
                end
                default: ;
            endcase
        end
        shift_en = enable && sample_en && !boundary && not_full &&
                   ((state_q == LEFT) || (state_q == RIGHT));
    end

    // Datapath next values: shift registers, bit count and frame outputs.
    always_comb begin
        lr_prev_d    = sample_en ? lr_s : lr_prev_q;
        cnt_d        = cnt_q;
        left_sr_d    = left_sr_q;
        right_sr_d   = right_sr_q;
        left_short_d = left_short_q;
        left_data_d  = left_data_q;
        right_data_d = right_data_q;
        frame_err_d  = frame_err_q;
        valid_d      = frame_done;

        if (!enable) begin
            cnt_d        = '0;
            left_sr_d    = '0;
            right_sr_d   = '0;
            left_short_d = 1'b0;
        end else begin
            if (start_left) begin
                cnt_d      = CW'(1);
                left_sr_d  = {{(WIDTH-1){1'b0}}, sd_s};
                right_sr_d = '0;
            end else if (start_right) begin
                cnt_d        = CW'(1);
                // The left word is frozen from here on, so justify it in place.
                left_sr_d    = left_sr_q << shamt;
                right_sr_d   = {{(WIDTH-1){1'b0}}, sd_s};
                left_short_d = not_full;
            end else if (shift_en) begin
                cnt_d = cnt_q + 1'b1;
                if (state_q == LEFT) begin
                    left_sr_d = {left_sr_q[WIDTH-2:0], sd_s};
                end else begin
                    right_sr_d = {right_sr_q[WIDTH-2:0], sd_s};
                end
            end

            if (frame_done) begin
                left_data_d  = left_sr_q;
                right_data_d = right_sr_q << shamt;
                frame_err_d  = left_short_q | not_full;
            end
        end
    end

    // Datapath registers; lr_prev resets high so a left-first start is not a boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lr_prev_q    <= 1'b1;
            cnt_q        <= '0;
            left_sr_q    <= '0;
            right_sr_q   <= '0;
            left_short_q <= 1'b0;
            left_data_q  <= '0;
            right_data_q <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            lr_prev_q    <= lr_prev_d;
            cnt_q        <= cnt_d;
            left_sr_q    <= left_sr_d;
            right_sr_q   <= right_sr_d;
            left_short_q <= left_short_d;
            left_data_q  <= left_data_d;
            right_data_q <= right_data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign left_data  = left_data_q;
    assign right_data = right_data_q;
    assign valid      = valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_adc_receiver.sv
// Self-checking bench for adc_receiver: a behavioural serial source feeds
// frames, expected words go into a scoreboard, valid pulses pop and compare.
module tb_adc_receiver;

    localparam int W    = 24;
    localparam int HALF = 40;   // sclk half period in ns (sclk = clk/8)

    typedef struct packed {
        logic [W-1:0] l;
        logic [W-1:0] r;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [W-1:0] left_data;
    logic [W-1:0] right_data;
    logic         valid;
    logic         frame_err;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t last_exp;
    int   vectors     = 0;
    int   miscompares = 0;

    adc_receiver_if bus ();

    always #5 clk = ~clk;

    adc_receiver #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .sclk       (bus.sclk),
        .lrclk      (bus.lrclk),
        .sd         (bus.sd),
        .left_data  (left_data),
        .right_data (right_data),
        .valid      (valid),
        .frame_err  (frame_err)
    );

    // Expected output word: first min(n, W) transmitted bits in the MSBs, zeros below.
    function automatic logic [W-1:0] expect_word(input logic [31:0] v, input int n);
        logic [W-1:0] w;
        logic [W-1:0] m;
        w = v[31:32-W];
        if (n >= W) m = '1;
        else        m = ~({W{1'b1}} >> n);
        return w & m;
    endfunction

    // Scoreboard monitor: every valid pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_valid: got pulse left=%h right=%h err=%b, required no pulse",
                         left_data, right_data, frame_err);
            end else begin
                mon_e = exp_q.pop_front();
                last_exp = mon_e;
                vectors++;
                if (left_data !== mon_e.l) begin
                    miscompares++;
                    $display("FAIL frame_left: got %h, required %h", left_data, mon_e.l);
                end
                vectors++;
                if (right_data !== mon_e.r) begin
                    miscompares++;
                    $display("FAIL frame_right: got %h, required %h", right_data, mon_e.r);
                end
                vectors++;
                if (frame_err !== mon_e.err) begin
                    miscompares++;
                    $display("FAIL frame_err: got %b, required %b", frame_err, mon_e.err);
                end
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #2;
    endtask

    // One sclk period: data and word select change on the falling edge.
    task automatic drive_bit(input logic lr, input logic b);
        bus.sclk  = 1'b0;
        bus.lrclk = lr;
        bus.sd    = b;
        #HALF;
        bus.sclk  = 1'b1;
        #HALF;
    endtask

    // Sends the top n bits of v, MSB first.
    task automatic send_channel(input logic lr, input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) drive_bit(lr, v[31-i]);
    endtask

    task automatic send_frame(input logic [31:0] lv, input int ln,
                              input logic [31:0] rv, input int rn);
        exp_t e;
        e.l   = expect_word(lv, ln);
        e.r   = expect_word(rv, rn);
        e.err = (ln < W) || (rn < W);
        exp_q.push_back(e);
        send_channel(1'b1, lv, ln);
        send_channel(1'b0, rv, rn);
    endtask

    // Leading left bit of a following frame closes the previous one.
    task automatic send_trailer();
        send_channel(1'b1, 32'h0, 1);
    endtask

    // Waits (bounded) for all expected frames to be presented, then a little more.
    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        repeat (10) @(posedge clk);
    endtask

    // Forces the receiver back to IDLE and starts the stream mid-right.
    task automatic restart();
        align();
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        enable = 1'b1;
        send_channel(1'b0, 32'h0, 4);
    endtask

    task automatic test_reset();
        bus.sclk  = 1'b1;
        bus.lrclk = 1'b0;
        bus.sd    = 1'b0;
        enable    = 1'b1;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (left_data !== '0) begin
            miscompares++;
            $display("FAIL reset_left: got %h, required 0", left_data);
        end
        vectors++;
        if (right_data !== '0) begin
            miscompares++;
            $display("FAIL reset_right: got %h, required 0", right_data);
        end
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b, required 0", valid);
        end
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err: got %b, required 0", frame_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_loopback();
        bit ok;
        restart();
        send_frame(32'hABCDEF00, 24, 32'h12345600, 24);
        send_frame(32'hABCDEF00, 24, 32'h12345600, 24);
        send_frame(32'h00000000, 24, 32'hFFFFFF00, 24);
        send_frame(32'hFFFFFF00, 24, 32'h00000100, 24);
        send_frame(32'h5A5A5A00, 24, 32'hA5A5A500, 24);
        send_trailer();
        wait_drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL loopback_drain: got %0d frames outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_mid_right_start();
        bit ok;
        align();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        send_channel(1'b0, 32'hDEADBEEF, 13);
        send_frame(32'h13579B00, 24, 32'h2468AC00, 24);
        send_trailer();
        wait_drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL mid_right_drain: got %0d frames outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_short_words();
        bit ok;
        restart();
        send_frame(32'hABCDEF00, 24, 32'hFFFFF000, 20);
        send_frame(32'h11223300, 24, 32'h44556600, 24);
        send_frame(32'hC3000000, 8,  32'h77777700, 24);
        send_frame(32'h99887700, 24, 32'h66554400, 24);
        send_trailer();
        wait_drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL short_drain: got %0d frames outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_long_left();
        bit ok;
        restart();
        send_frame(32'h800001F0, 28, 32'h0F0F0F00, 24);
        send_frame(32'h7FFFFE50, 28, 32'hF0F0F0A0, 28);
        send_trailer();
        wait_drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL long_drain: got %0d frames outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_left();
        bit ok;
        restart();
        send_channel(1'b1, 32'hFFFFFFFF, 10);
        align();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (left_data !== '0 || right_data !== '0 || valid !== 1'b0 || frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got left=%h right=%h valid=%b err=%b, required all 0",
                     left_data, right_data, valid, frame_err);
        end
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        send_channel(1'b1, 32'hFFFFFFFF, 14);
        send_channel(1'b0, 32'hFFFFFFFF, 24);
        send_frame(32'h5A5A5A00, 24, 32'hC3C3C300, 24);
        send_trailer();
        wait_drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL mid_reset_drain: got %0d frames outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        restart();
        send_channel(1'b1, 32'h12345600, 24);
        send_channel(1'b0, 32'hFFFFFFFF, 12);
        align();
        enable = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        vectors++;
        if (left_data !== last_exp.l || right_data !== last_exp.r || frame_err !== last_exp.err) begin
            miscompares++;
            $display("FAIL enable_hold: got left=%h right=%h err=%b, required left=%h right=%h err=%b",
                     left_data, right_data, frame_err, last_exp.l, last_exp.r, last_exp.err);
        end
        enable = 1'b1;
        send_channel(1'b0, 32'hFFFFFFFF, 12);
        send_frame(32'hFEDCBA00, 24, 32'h01234500, 24);
        send_trailer();
        wait_drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL enable_drain: got %0d frames outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_mid_right_start();
        test_short_words();
        test_long_left();
        test_reset_mid_left();
        test_enable_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
